ringbuf_mp: RTL and testbench

- Multi-port circular buffer: up to NW entries enqueued and up to NR entries dequeued per cycle.
- Successor to the single-port ring buffer used for in-order commit queues in the core (ROB and store-queue style tracking).
- Adds occupancy and free counts, all-or-nothing request acceptance, non-power-of-two depth, flush and error pulses.
- Read lanes present the oldest NR entries in parallel.

---
 rtl/ringbuf_mp.sv | 125 ++++++++++++
 tb/tb_ringbuf_mp.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ringbuf_mp.sv
// ringbuf_mp: multi-port circular buffer for in-order commit tracking.
// Up to NW entries are enqueued and up to NR dequeued per cycle. The oldest
// NR entries are presented in parallel on the read lanes. Free slots always
// hold zero, so invalid read lanes show 0 once a slot has been popped or cleared.
module ringbuf_mp #(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 16,
   parameter  int NW    = 2,
   parameter  int NR    = 2,
   localparam int CW    = $clog2(DEPTH + 1),
   localparam int PNW   = $clog2(NW + 1),
   localparam int PNR   = $clog2(NR + 1)
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_flush,
   input  logic [PNW-1:0]      i_push_n,
   input  logic [NW*WIDTH-1:0] i_data,
   input  logic [PNR-1:0]      i_pop_n,
   output logic [NR*WIDTH-1:0] o_data,
   output logic [NR-1:0]       o_valid,
   output logic [CW-1:0]       o_count,
   output logic [CW-1:0]       o_free,
   output logic                o_empty,
   output logic                o_full,
   output logic                o_push_rdy,
   output logic                o_pop_rdy,
   output logic [1:0]          o_err
);

   // Pointer width; a one-entry buffer still gets a 1-bit pointer.
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // (p + n) mod DEPTH. The sum is one bit wider than the pointer, and both
   // p < DEPTH and n <= DEPTH hold, so a single subtraction is enough.
   function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input logic [PW:0] n);
      logic [PW:0] s;
      s = {1'b0, p} + n;
      if (s >= (PW+1)'(DEPTH)) s = s - (PW+1)'(DEPTH);
      return s[PW-1:0];
   endfunction

   logic [PW-1:0]    head_q, head_d;
   logic [PW-1:0]    tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;
   logic [1:0]       err_q, err_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];

   logic [CW-1:0]    free;
   logic             push_ok, pop_ok;
   logic [CW-1:0]    push_cnt, pop_cnt;

   // Acceptance against pre-edge occupancy; out-of-range requests count as 0 and are flagged.
   always_comb begin
      free     = CW'(DEPTH) - count_q;
      push_ok  = (int'(i_push_n) <= NW) && (int'(i_push_n) <= int'(free));
      pop_ok   = (int'(i_pop_n) <= NR) && (int'(i_pop_n) <= int'(count_q));
      push_cnt = push_ok ? CW'(i_push_n) : '0;
      pop_cnt  = pop_ok ? CW'(i_pop_n) : '0;
      err_d    = {(i_pop_n != '0) && !pop_ok, (i_push_n != '0) && !push_ok};
      count_d  = count_q + push_cnt - pop_cnt;
      head_d   = wrap_add(head_q, (PW+1)'(pop_cnt));
      tail_d   = wrap_add(tail_q, (PW+1)'(push_cnt));
   end

   // Next memory image: popped slots are zeroed, pushed lanes land in free slots.
   // The two sets are disjoint because both are measured before the edge.
   always_comb begin
      mem_d = mem_q;
      for (int k = 0; k < NR; k++) begin
         if (k < int'(pop_cnt)) mem_d[wrap_add(head_q, (PW+1)'(k))] = '0;
      end
      for (int k = 0; k < NW; k++) begin
         if (k < int'(push_cnt)) mem_d[wrap_add(tail_q, (PW+1)'(k))] = i_data[k*WIDTH +: WIDTH];
      end
   end

   // Control state: flush wins over push and pop and clears the error pulses.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         err_q   <= '0;
      end else if (i_flush) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         err_q   <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   // Entry storage: cleared on reset and flush so empty slots read as zero.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (i_flush) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      end
   end

   // Read lanes and status, all derived from registered state except the ready flags.
   always_comb begin
      for (int k = 0; k < NR; k++) begin
         o_data[k*WIDTH +: WIDTH] = mem_q[wrap_add(head_q, (PW+1)'(k))];
         o_valid[k]               = (k < int'(count_q));
      end
      o_count    = count_q;
      o_free     = free;
      o_empty    = (count_q == '0);
      o_full     = (count_q == CW'(DEPTH));
      o_push_rdy = (int'(i_push_n) <= int'(free));
      o_pop_rdy  = (int'(i_pop_n) <= int'(count_q));
      o_err      = err_q;
   end

endmodule

// File: tb/tb_ringbuf_mp.sv
// tb_ringbuf_mp: directed table, corner sequences and random traffic for
// ringbuf_mp (WIDTH=8, DEPTH=5, NW=2, NR=2), checked against a queue model.
module tb_ringbuf_mp;

   localparam int WIDTH = 8;
   localparam int DEPTH = 5;
   localparam int NW    = 2;
   localparam int NR    = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic [1:0]  push_n;
   logic [15:0] din;
   logic [1:0]  pop_n;
   logic [15:0] dout;
   logic [1:0]  valid;
   logic [2:0]  count, free;
   logic        empty, full, push_rdy, pop_rdy;
   logic [1:0]  err;

   ringbuf_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NW(NW), .NR(NR)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_push_n(push_n),
      .i_data(din), .i_pop_n(pop_n), .o_data(dout), .o_valid(valid),
      .o_count(count), .o_free(free), .o_empty(empty), .o_full(full),
      .o_push_rdy(push_rdy), .o_pop_rdy(pop_rdy), .o_err(err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference model: the buffer contents as an ordered list, oldest first.
   logic [7:0] mq[$];
   logic [1:0] m_err;

   typedef struct {
      logic       fl;
      logic [1:0] pn;
      logic [7:0] d0, d1;
      logic [1:0] pm;
      int         e_cnt;
      logic [7:0] e_d0, e_d1;
      logic [1:0] e_err;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] m_lane(input int k);
      return (k < mq.size()) ? mq[k] : 8'h00;
   endfunction

   task automatic check_model(input string tag);
      chk({tag, "_count"}, 32'(count), 32'(mq.size()));
      chk({tag, "_free"},  32'(free),  32'(DEPTH - mq.size()));
      chk({tag, "_empty"}, 32'(empty), 32'(mq.size() == 0));
      chk({tag, "_full"},  32'(full),  32'(mq.size() == DEPTH));
      chk({tag, "_valid"}, 32'(valid), {30'd0, mq.size() > 1, mq.size() > 0});
      chk({tag, "_data"},  32'(dout),  {16'd0, m_lane(1), m_lane(0)});
      chk({tag, "_err"},   32'(err),   32'(m_err));
   endtask

   // One clock: drive, check ready flags before the edge, update the model, check after.
   task automatic step(input logic fl, input logic [1:0] pn, input logic [7:0] d0,
                       input logic [7:0] d1, input logic [1:0] pm, input string tag);
      int  cnt;
      bit  pok, mok;
      flush  = fl;
      push_n = pn;
      din    = {d1, d0};
      pop_n  = pm;
      #1;
      cnt = mq.size();
      chk({tag, "_push_rdy"}, 32'(push_rdy), 32'(int'(pn) <= DEPTH - cnt));
      chk({tag, "_pop_rdy"},  32'(pop_rdy),  32'(int'(pm) <= cnt));
      @(posedge clk);
      pok = (int'(pn) <= NW) && (int'(pn) <= DEPTH - cnt);
      mok = (int'(pm) <= NR) && (int'(pm) <= cnt);
      if (fl) begin
         mq.delete();
         m_err = 2'b00;
      end else begin
         if (mok) for (int i = 0; i < int'(pm); i++) void'(mq.pop_front());
         if (pok) begin
            if (pn >= 2'd1) mq.push_back(d0);
            if (pn >= 2'd2) mq.push_back(d1);
         end
         m_err = {pm != 2'd0 && !mok, pn != 2'd0 && !pok};
      end
      #1;
      flush  = 1'b0;
      push_n = 2'd0;
      pop_n  = 2'd0;
      check_model(tag);
   endtask

   initial begin
      rst_n  = 1'b0;
      flush  = 1'b0;
      push_n = 2'd0;
      pop_n  = 2'd0;
      din    = 16'h0;
      m_err  = 2'b00;

      // Directed table from reset: basic push, fill to full, rejected push,
      // full with push+pop, error pulse width, single pop.
      vecs[0] = '{1'b0, 2'd2, 8'h11, 8'h22, 2'd0, 2, 8'h11, 8'h22, 2'b00};
      vecs[1] = '{1'b0, 2'd0, 8'h00, 8'h00, 2'd2, 0, 8'h00, 8'h00, 2'b00};
      vecs[2] = '{1'b0, 2'd2, 8'h01, 8'h02, 2'd0, 2, 8'h01, 8'h02, 2'b00};
      vecs[3] = '{1'b0, 2'd2, 8'h03, 8'h04, 2'd0, 4, 8'h01, 8'h02, 2'b00};
      vecs[4] = '{1'b0, 2'd1, 8'h05, 8'hEE, 2'd0, 5, 8'h01, 8'h02, 2'b00};
      vecs[5] = '{1'b0, 2'd1, 8'h66, 8'h00, 2'd0, 5, 8'h01, 8'h02, 2'b01};
      vecs[6] = '{1'b0, 2'd2, 8'hAA, 8'hBB, 2'd2, 3, 8'h03, 8'h04, 2'b01};
      vecs[7] = '{1'b0, 2'd0, 8'h00, 8'h00, 2'd0, 3, 8'h03, 8'h04, 2'b00};
      vecs[8] = '{1'b0, 2'd0, 8'h00, 8'h00, 2'd1, 2, 8'h04, 8'h05, 2'b00};

      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_model("reset");
      chk("reset_free5", 32'(free), 32'd5);
      chk("reset_data0", 32'(dout), 32'd0);

      foreach (vecs[i]) begin
         step(vecs[i].fl, vecs[i].pn, vecs[i].d0, vecs[i].d1, vecs[i].pm, $sformatf("tbl%0d", i));
         chk($sformatf("tbl%0d_exp_count", i), 32'(count), 32'(vecs[i].e_cnt));
         chk($sformatf("tbl%0d_exp_data", i),  32'(dout),  {16'd0, vecs[i].e_d1, vecs[i].e_d0});
         chk($sformatf("tbl%0d_exp_err", i),   32'(err),   32'(vecs[i].e_err));
      end

      // Wrap: two in, two out each cycle; lanes always show the pair just pushed.
      for (int i = 0; i < 6; i++) begin
         logic [7:0] a, b;
         a = 8'(8'h30 + 2 * i);
         b = 8'(8'h31 + 2 * i);
         step(1'b0, 2'd2, a, b, 2'd2, $sformatf("wrap%0d", i));
         chk($sformatf("wrap%0d_exp", i), {count, dout}, {3'd2, b, a});
      end

      // Over-pop at count 1 is rejected, then the last entry drains to empty.
      step(1'b0, 2'd0, 8'h00, 8'h00, 2'd1, "pop1");
      chk("pop1_exp", {count, dout}, {3'd1, 8'h00, 8'h3B});
      step(1'b0, 2'd0, 8'h00, 8'h00, 2'd2, "overpop");
      chk("overpop_exp", {err, count, dout}, {2'b10, 3'd1, 8'h00, 8'h3B});
      step(1'b0, 2'd0, 8'h00, 8'h00, 2'd1, "drain");
      chk("drain_exp", {err, count, dout}, {2'b00, 3'd0, 16'h0000});

      // Empty with pop and push together: pop rejected, data visible next cycle.
      step(1'b0, 2'd1, 8'h77, 8'h00, 2'd1, "emptypp");
      chk("emptypp_exp", {err, count, dout}, {2'b10, 3'd1, 8'h00, 8'h77});

      // Flush with a push pending at count 3, then flush masking a bad pop.
      step(1'b0, 2'd2, 8'hA1, 8'hA2, 2'd0, "pre_flush");
      step(1'b1, 2'd2, 8'hB1, 8'hB2, 2'd0, "flush");
      chk("flush_exp", {err, empty, count, dout}, {2'b00, 1'b1, 3'd0, 16'h0000});
      step(1'b1, 2'd0, 8'h00, 8'h00, 2'd2, "flush_err");

      // Asynchronous reset in the middle of a cycle with four entries held.
      step(1'b0, 2'd2, 8'hC1, 8'hC2, 2'd0, "pre_rst_a");
      step(1'b0, 2'd2, 8'hC3, 8'hC4, 2'd0, "pre_rst_b");
      #2 rst_n = 1'b0;
      #1;
      mq.delete();
      m_err = 2'b00;
      check_model("async_rst");
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Random traffic including out-of-range request counts and rare flushes.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 29) == 0), 2'($urandom_range(0, 3)), 8'($urandom),
              8'($urandom), 2'($urandom_range(0, 3)), "rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
